dispatcher: RTL and testbench

DISPATCHER -- requirements
Module: dispatcher

---
 rtl/dispatcher_pkg.sv | 11 +
 rtl/dispatcher.sv | 139 +++++++++++++
 tb/tb_dispatcher.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dispatcher_pkg.sv
// Shared miniGPU constants: default core/thread geometry and dispatcher state encodings.
package dispatcher_pkg;

    localparam int DEF_NUM_CORES         = 2;
    localparam int DEF_THREADS_PER_BLOCK = 4;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPATCH = 2'd1;
    localparam logic [1:0] S_DONE     = 2'd2;

endpackage

// File: rtl/dispatcher.sv
// Block dispatcher: splits a kernel launch into thread blocks and hands them
// one per cycle to the lowest-index idle core, then signals kernel completion.
module dispatcher
    import dispatcher_pkg::*;
#(
    parameter int NUM_CORES         = DEF_NUM_CORES,
    parameter int THREADS_PER_BLOCK = DEF_THREADS_PER_BLOCK
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               thread_count,
    input  logic [NUM_CORES-1:0]     core_done,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [NUM_CORES-1:0]     core_reset,
    output logic [8*NUM_CORES-1:0]   core_block_id,
    output logic [5*NUM_CORES-1:0]   core_thread_count,
    output logic                     done
);

    localparam int TPB_LOG2 = $clog2(THREADS_PER_BLOCK);

    logic [1:0]           state;
    logic [7:0]           latched_count;
    logic [8:0]           total_blocks;
    logic [8:0]           dispatched;
    logic [8:0]           completed;
    logic                 launch;
    logic                 in_dispatch;
    logic [NUM_CORES-1:0] free_core;
    logic [NUM_CORES-1:0] finishing;
    logic [NUM_CORES-1:0] grant;
    logic [8:0]           finish_count;
    logic [8:0]           remaining;
    logic [4:0]           block_count;
    logic                 found;

    assign launch      = (state == S_IDLE) && start;
    assign in_dispatch = (state == S_DISPATCH);
    assign free_core   = ~core_start & ~core_reset;
    assign finishing   = core_done & core_start & {NUM_CORES{in_dispatch}};

    // Block ids are always below total_blocks, so the remainder never underflows.
    assign remaining   = {1'b0, latched_count} - (dispatched << TPB_LOG2);
    assign block_count = (remaining >= 9'(THREADS_PER_BLOCK)) ? 5'(THREADS_PER_BLOCK)
                                                               : remaining[4:0];

    always_comb begin
        grant = '0;
        found = 1'b0;
        if (in_dispatch && (dispatched < total_blocks)) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (free_core[i] && !found) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        finish_count = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            finish_count = finish_count + 9'(finishing[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            latched_count <= '0;
            total_blocks  <= '0;
            dispatched    <= '0;
            completed     <= '0;
            done          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        latched_count <= thread_count;
                        total_blocks  <= ({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> TPB_LOG2;
                        dispatched    <= '0;
                        completed     <= '0;
                        state         <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (completed == total_blocks) begin
                        state <= S_DONE;
                    end else begin
                        if (|grant) dispatched <= dispatched + 9'd1;
                        completed <= completed + finish_count;
                    end
                end
                S_DONE: begin
                    // done is raised for at least one cycle, then waits for start to drop.
                    if (!done) begin
                        done <= 1'b1;
                    end else if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        logic       run_q;
        logic       rst_q;
        logic [7:0] id_q;
        logic [4:0] cnt_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                run_q <= 1'b0;
                rst_q <= 1'b0;
                id_q  <= '0;
                cnt_q <= '0;
            end else begin
                rst_q <= launch | finishing[i];
                if (grant[i]) begin
                    run_q <= 1'b1;
                    id_q  <= dispatched[7:0];
                    cnt_q <= block_count;
                end else if (finishing[i]) begin
                    run_q <= 1'b0;
                end
            end
        end

        assign core_start[i]            = run_q;
        assign core_reset[i]            = rst_q;
        assign core_block_id[8*i +: 8]  = id_q;
        assign core_thread_count[5*i +: 5] = cnt_q;
    end

endmodule

// File: tb/tb_dispatcher.sv
// Directed self-checking bench for the dispatcher with hand-computed timing.
module tb_dispatcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  thread_count;
    logic [1:0]  core_done;
    logic [1:0]  core_start;
    logic [1:0]  core_reset;
    logic [15:0] core_block_id;
    logic [9:0]  core_thread_count;
    logic        done;

    int assertions = 0;
    int failures   = 0;

    dispatcher dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .core_done         (core_done),
        .core_start        (core_start),
        .core_reset        (core_reset),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; thread_count = 8'd0; core_done = 2'b00;
        tick(); tick();
        assertions++; if (core_start !== 2'b00) begin failures++; $display("[TB] FAIL reset_start got %b want 00", core_start); end
        assertions++; if (core_reset !== 2'b00) begin failures++; $display("[TB] FAIL reset_creset got %b want 00", core_reset); end
        assertions++; if (core_block_id !== 16'h0) begin failures++; $display("[TB] FAIL reset_id got %h want 0000", core_block_id); end
        assertions++; if (core_thread_count !== 10'h0) begin failures++; $display("[TB] FAIL reset_cnt got %h want 000", core_thread_count); end
        assertions++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b want 0", done); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_eight;
        thread_count = 8'd8; start = 1'b1;
        tick();
        assertions++; if (core_reset !== 2'b11) begin failures++; $display("[TB] FAIL t8_launch_reset got %b want 11", core_reset); end
        tick();
        assertions++; if (core_reset !== 2'b00 || core_start !== 2'b00) begin failures++; $display("[TB] FAIL t8_n1 got rst=%b run=%b want 00/00", core_reset, core_start); end
        tick();
        assertions++; if (core_start !== 2'b01) begin failures++; $display("[TB] FAIL t8_n2_start got %b want 01", core_start); end
        assertions++; if (core_block_id[7:0] !== 8'd0 || core_thread_count[4:0] !== 5'd4) begin failures++; $display("[TB] FAIL t8_core0 got id=%0d cnt=%0d want 0/4", core_block_id[7:0], core_thread_count[4:0]); end
        tick();
        assertions++; if (core_start !== 2'b11) begin failures++; $display("[TB] FAIL t8_n3_start got %b want 11", core_start); end
        assertions++; if (core_block_id[15:8] !== 8'd1 || core_thread_count[9:5] !== 5'd4) begin failures++; $display("[TB] FAIL t8_core1 got id=%0d cnt=%0d want 1/4", core_block_id[15:8], core_thread_count[9:5]); end
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        assertions++; if (core_start !== 2'b00 || core_reset !== 2'b11) begin failures++; $display("[TB] FAIL t8_both_done got run=%b rst=%b want 00/11", core_start, core_reset); end
        tick();
        assertions++; if (core_reset !== 2'b00 || done !== 1'b0) begin failures++; $display("[TB] FAIL t8_e1 got rst=%b done=%b want 00/0", core_reset, done); end
        tick();
        assertions++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL t8_done got %b want 1", done); end
        tick(); tick();
        assertions++; if (done !== 1'b1 || core_start !== 2'b00 || core_reset !== 2'b00) begin failures++; $display("[TB] FAIL t8_hold got done=%b run=%b rst=%b want 1/00/00", done, core_start, core_reset); end
        start = 1'b0;
        tick();
        assertions++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL t8_clear got %b want 0", done); end
        tick();
    endtask

    task automatic test_ragged;
        thread_count = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        assertions++; if (core_start !== 2'b11) begin failures++; $display("[TB] FAIL t10_busy got %b want 11", core_start); end
        core_done = 2'b10;
        tick();
        core_done = 2'b00;
        assertions++; if (core_start !== 2'b01 || core_reset !== 2'b10) begin failures++; $display("[TB] FAIL t10_free1 got run=%b rst=%b want 01/10", core_start, core_reset); end
        tick();
        assertions++; if (core_start !== 2'b01 || core_reset !== 2'b00) begin failures++; $display("[TB] FAIL t10_wait got run=%b rst=%b want 01/00", core_start, core_reset); end
        tick();
        assertions++; if (core_start !== 2'b11) begin failures++; $display("[TB] FAIL t10_regrant got %b want 11", core_start); end
        assertions++; if (core_block_id[15:8] !== 8'd2 || core_thread_count[9:5] !== 5'd2) begin failures++; $display("[TB] FAIL t10_block2 got id=%0d cnt=%0d want 2/2", core_block_id[15:8], core_thread_count[9:5]); end
        assertions++; if (core_block_id[7:0] !== 8'd0 || core_thread_count[4:0] !== 5'd4) begin failures++; $display("[TB] FAIL t10_core0_stable got id=%0d cnt=%0d want 0/4", core_block_id[7:0], core_thread_count[4:0]); end
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        tick(); tick();
        assertions++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL t10_done got %b want 1", done); end
        tick();
        assertions++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL t10_clear got %b want 0", done); end
    endtask

    task automatic test_zero;
        thread_count = 8'd0; start = 1'b1;
        tick();
        assertions++; if (core_reset !== 2'b11) begin failures++; $display("[TB] FAIL t0_launch_reset got %b want 11", core_reset); end
        tick();
        assertions++; if (done !== 1'b0 || core_start !== 2'b00) begin failures++; $display("[TB] FAIL t0_n1 got done=%b run=%b want 0/00", done, core_start); end
        tick();
        assertions++; if (done !== 1'b1 || core_start !== 2'b00) begin failures++; $display("[TB] FAIL t0_n2 got done=%b run=%b want 1/00", done, core_start); end
        start = 1'b0;
        tick();
        assertions++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL t0_clear got %b want 0", done); end
    endtask

    task automatic test_reset_mid;
        thread_count = 8'd8; start = 1'b1;
        tick(); tick(); tick();
        assertions++; if (core_start !== 2'b01) begin failures++; $display("[TB] FAIL rm_pre got %b want 01", core_start); end
        #2 reset = 1'b0;
        #1;
        assertions++; if (core_start !== 2'b00 || core_reset !== 2'b00 || done !== 1'b0) begin failures++; $display("[TB] FAIL rm_async got run=%b rst=%b done=%b want 00/00/0", core_start, core_reset, done); end
        assertions++; if (core_block_id !== 16'h0 || core_thread_count !== 10'h0) begin failures++; $display("[TB] FAIL rm_async_data got id=%h cnt=%h want 0/0", core_block_id, core_thread_count); end
        start = 1'b0;
        core_done = 2'b11;
        #2 reset = 1'b1;
        tick(); tick(); tick();
        assertions++; if (core_start !== 2'b00 || core_reset !== 2'b00 || done !== 1'b0) begin failures++; $display("[TB] FAIL rm_stray got run=%b rst=%b done=%b want 00/00/0", core_start, core_reset, done); end
        core_done = 2'b00;
        tick();
    endtask

    task automatic test_full_range;
        logic [1:0] prev_start;
        int         next_id;
        logic [4:0] want_cnt;
        logic       saw_done;
        thread_count = 8'd255; start = 1'b1;
        tick();
        thread_count = 8'd4; start = 1'b0;
        prev_start = 2'b00; next_id = 0; saw_done = 1'b0;
        for (int cyc = 0; cyc < 1000 && !saw_done; cyc++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
            for (int c = 0; c < 2; c++) begin
                if (core_start[c] && !prev_start[c]) begin
                    want_cnt = (next_id == 63) ? 5'd3 : 5'd4;
                    assertions++;
                    if (core_block_id[8*c +: 8] !== 8'(next_id) || core_thread_count[5*c +: 5] !== want_cnt) begin
                        failures++;
                        $display("[TB] FAIL t255_block got core%0d id=%0d cnt=%0d want %0d/%0d", c, core_block_id[8*c +: 8], core_thread_count[5*c +: 5], next_id, want_cnt);
                    end
                    next_id++;
                end
            end
            prev_start = core_start;
            core_done  = core_start;
        end
        core_done = 2'b00;
        assertions++; if (!saw_done) begin failures++; $display("[TB] FAIL t255_timeout got done=%b want 1 within 1000 cycles", done); end
        assertions++; if (next_id != 64) begin failures++; $display("[TB] FAIL t255_blocks got %0d want 64", next_id); end
        tick();
        assertions++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL t255_clear got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_eight();
        test_ragged();
        test_zero();
        test_reset_mid();
        test_full_range();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
